// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types and data-bus lane helpers.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } load_size_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    ALU      = 2'd1,
    MEM_REQ  = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      HALF:    is_misaligned = lo[0];
      WORD:    is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      BYTE:    lane_mask = 4'b0001 << lo;
      HALF:    lane_mask = 4'b0011 << lo;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic word_t lane_replicate(input logic [1:0] size, input word_t d);
    case (size)
      BYTE:    lane_replicate = {4{d[7:0]}};
      HALF:    lane_replicate = {2{d[15:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/stage3_load_extract.sv
// Selects the addressed lane of a bus read word and sign/zero-extends it.
module stage3_load_extract
  import rv32i_types_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      BYTE:    data_o = unsigned_i ? {24'b0, byte_sel} : 32'($signed(byte_sel));
      HALF:    data_o = unsigned_i ? {16'b0, half_sel} : 32'($signed(half_sel));
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage3_mem_fwd_source.sv
// Memory-stage register of the 3-stage core: sequences data-bus accesses,
// sources the mem-side forwarding values and retires results to writeback.
module stage3_mem_fwd_source
  import rv32i_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wen,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_store_data,
  input  logic        flush,
  output logic        dbus_ren,
  output logic        dbus_wen,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_byte_en,
  input  logic        dbus_busy,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  rd_mem,
  output logic [31:0] rd_mem_data,
  output logic        regWEN,
  output logic        load,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  mem_state_t  state_q, state_d;
  logic        flushed_q, flushed_d;
  logic [4:0]  rd_q;
  logic        reg_wen_q, load_q, store_q, unsigned_q, mis_q;
  logic [1:0]  size_q;
  logic [31:0] alu_q, sdata_q, ldata_q, extract_w;
  logic        retire, accept, bus_done, rd_nz, acc_mis, acc_mem;

  assign rd_nz    = (rd_q != 5'd0);
  assign bus_done = (state_q == MEM_REQ) && !dbus_busy;
  assign retire   = (state_q == ALU) || (state_q == MEM_DONE) || (bus_done && store_q);
  // A flush squashes execute as well, so nothing is taken in that cycle.
  assign ex_ready = ((state_q == EMPTY) || retire) && !flush;
  assign accept   = ex_valid && ex_ready;
  assign acc_mis  = (ex_load || ex_store) && is_misaligned(ex_size, ex_alu[1:0]);
  assign acc_mem  = (ex_load || ex_store) && !acc_mis;

  stage3_load_extract u_extract (
    .rdata_i    (dbus_rdata),
    .addr_lo_i  (alu_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (extract_w)
  );

  always_comb begin
    state_d   = state_q;
    flushed_d = flushed_q;
    if (accept) begin
      state_d   = acc_mem ? MEM_REQ : ALU;
      flushed_d = 1'b0;
    end else if (retire) begin
      state_d   = EMPTY;
      flushed_d = 1'b0;
    end else if (state_q == MEM_REQ) begin
      // A flushed access still completes on the bus; only its result is dropped.
      flushed_d = flushed_q || flush;
      if (bus_done) state_d = MEM_DONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= EMPTY;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      rd_q       <= ex_rd;
      reg_wen_q  <= ex_reg_wen;
      load_q     <= ex_load;
      store_q    <= ex_store;
      size_q     <= ex_size;
      unsigned_q <= ex_unsigned;
      alu_q      <= ex_alu;
      sdata_q    <= ex_store_data;
      mis_q      <= acc_mis;
    end
    if (bus_done && load_q) ldata_q <= extract_w;
  end

  always_comb begin
    rd_mem       = 5'd0;
    rd_mem_data  = 32'd0;
    regWEN       = 1'b0;
    load         = 1'b0;
    misaligned   = 1'b0;
    dbus_ren     = 1'b0;
    dbus_wen     = 1'b0;
    dbus_addr    = 32'd0;
    dbus_wdata   = 32'd0;
    dbus_byte_en = 4'd0;
    case (state_q)
      ALU: begin
        rd_mem      = rd_q;
        rd_mem_data = alu_q;
        regWEN      = reg_wen_q && rd_nz && !mis_q;
        misaligned  = mis_q;
      end
      MEM_REQ: begin
        rd_mem       = rd_q;
        load         = load_q;
        regWEN       = load_q && rd_nz;
        dbus_ren     = load_q && !RST;
        dbus_wen     = store_q && !RST;
        dbus_addr    = {alu_q[31:2], 2'b00};
        dbus_byte_en = lane_mask(size_q, alu_q[1:0]);
        dbus_wdata   = store_q ? lane_replicate(size_q, sdata_q) : 32'd0;
      end
      MEM_DONE: begin
        rd_mem      = rd_q;
        rd_mem_data = ldata_q;
        regWEN      = rd_nz && !flushed_q;
      end
      default: ;
    endcase
  end

  assign wb_wen  = retire && regWEN && !flush && !flushed_q;
  assign wb_rd   = rd_mem;
  assign wb_data = rd_mem_data;

endmodule

// File: doc/stage3_mem_fwd_source.md
# stage3_mem_fwd_source

Memory-stage pipeline register and data-bus sequencer for the 3-stage core. It accepts instructions from execute, runs loads and stores on the data bus, and publishes `rd_mem`, `rd_mem_data`, `regWEN` and `load` to the forwarding unit. It retires results to writeback. It is the producer end of the `stage3_forwarding_unit_if` mem modport.

## Interface
Parameters:
- none. Widths are fixed by `rv32i_types_pkg::word_t` (32 bits).

Ports:
- `CLK` in 1: core clock. Single clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: execute presents an instruction.
- `ex_ready` out 1: this stage accepts the instruction. The transfer happens when `ex_valid && ex_ready`.
- `ex_rd` in 5: destination register.
- `ex_reg_wen` in 1: instruction writes `rd`.
- `ex_load`, `ex_store` in 1 each: memory op. The two are mutually exclusive.
- `ex_size` in 2: `load_size_t` (BYTE=0, HALF=1, WORD=2).
- `ex_unsigned` in 1: zero-extend loads.
- `ex_alu` in 32: ALU result, or the effective address for memory ops.
- `ex_store_data` in 32: rs2 value.
- `flush` in 1: squash the held instruction.
- `dbus_ren`, `dbus_wen` out 1 each: bus request.
- `dbus_addr` out 32: word-aligned address.
- `dbus_wdata` out 32: store data replicated into lanes.
- `dbus_byte_en` out 4: lane enables.
- `dbus_busy` in 1: the access is incomplete.
- `dbus_rdata` in 32: read data, valid in the cycle `dbus_busy` is 0.
- `rd_mem` out 5: forwarding destination.
- `rd_mem_data` out 32: forwarding value.
- `regWEN` out 1: forwarding value is a real register write.
- `load` out 1: the held instruction is a load whose data is not yet available.
- `wb_wen` out 1: one-cycle retire strobe.
- `wb_rd` out 5: writeback destination.
- `wb_data` out 32: writeback value.
- `misaligned` out 1: one-cycle strobe when a misaligned access is dropped.

## Operation
- State register `mem_state_t`:
  - EMPTY
  - ALU: a non-memory instruction is held.
  - MEM_REQ: a bus access is outstanding.
  - MEM_DONE: load data has been captured.
- Reset: state EMPTY. Every output is 0 except `ex_ready`=1.
- `retire` is true in any of these cases:
  - state ALU;
  - state MEM_DONE;
  - state MEM_REQ with a store and `dbus_busy`=0.
- `ex_ready` = (state EMPTY) or `retire`.
- Accept (`ex_valid && ex_ready`):
  - Latch all `ex_*` fields.
  - Next state is MEM_REQ if `ex_load` or `ex_store` and the access is aligned. Otherwise it is ALU.
- Misaligned accesses are HALF with addr[0]=1, or WORD with addr[1:0]≠0.
  - They go to ALU with `regWEN` forced to 0.
  - `misaligned` pulses at retire.
  - No bus access is made.
- EMPTY: `rd_mem`=0, `regWEN`=0, `load`=0, `rd_mem_data`=0.
- ALU: `rd_mem_data` = latched ALU value, `regWEN` = `reg_wen && rd≠0`, `load`=0.
- MEM_REQ:
  - `dbus_ren`/`dbus_wen` are held until `dbus_busy`=0.
  - `load`=1 for loads. `rd_mem_data`=0.
  - `regWEN` = load && rd≠0.
  - Stores: `regWEN`=0, and the stage retires when the bus completes.
  - Loads: when the bus completes, capture the extracted data and go to MEM_DONE.
- MEM_DONE: `load`=0, `rd_mem_data` = extracted data, `regWEN` = rd≠0.
- Lane rules:
  - `dbus_addr` = {addr[31:2], 2'b00}.
  - `dbus_byte_en`: BYTE gives 0001<<addr[1:0]; HALF gives 0011<<addr[1:0]; WORD gives 1111.
  - `dbus_wdata`: the byte is replicated ×4, or the half is replicated ×2.
  - The load lane is selected by addr[1:0], then sign- or zero-extended to 32 bits.
- Retire:
  - `wb_wen`=`regWEN`, with `wb_rd` and `wb_data` taken from the current forwarding values.
  - The next state is the accepted instruction's state, or EMPTY if nothing is accepted.
- Flush:
  - In EMPTY or ALU, the next state is EMPTY with no `wb_wen`. Same-cycle accept is blocked.
  - In MEM_REQ, the bus access runs to completion, but writeback and MEM_DONE forwarding are suppressed. The flushed flag is cleared on retire.
- `rd`=0 never produces `regWEN` or `wb_wen`.

## Timing
- ALU op accepted in cycle N:
  - Forwarding is visible in N+1 and `wb_wen` pulses in N+1.
  - Back-to-back ALU ops sustain 1 per cycle.
- Load accepted in N, with `dbus_busy` high for k cycles:
  - `dbus_ren` and `load`=1 during N+1 … N+1+k.
  - `dbus_rdata` is sampled at N+1+k.
  - MEM_DONE and forwarding data in N+2+k, with retire in that cycle.
  - Latency is 2+k.
- Store: `dbus_wen` from N+1, retire in the cycle `dbus_busy`=0. Latency is 1+k.
- All outputs are registered state or combinational from state, latched fields and `dbus_busy`/`dbus_rdata`. There is no combinational path from `ex_*` to the outputs.
- `RST` asserted mid-access: state is EMPTY in the next cycle and bus requests drop immediately.

## Structure
- `load_size_t` and `mem_state_t` belong in `rv32i_types_pkg`.
- Sub-module `stage3_load_extract` is combinational:
  - inputs: rdata, addr[1:0], size, unsigned;
  - output: the 32-bit extended word;
  - it is reused by the other pipelines.

## Test plan
- ALU op, rd=5, alu=0x1234: in the next cycle `rd_mem`=5, `rd_mem_data`=0x1234, `regWEN`=1, `load`=0, `wb_wen`=1. Back-to-back ops show `ex_ready` held at 1.
- LB signed, addr 0x103, rdata 0x80FF_FF00, busy=2 cycles:
  - `load`=1 for 3 cycles;
  - then `rd_mem_data`=0xFFFF_FF80 and `wb_wen` pulses;
  - `ex_ready`=0 throughout the access.
- SH, addr 0x202, data 0xABCD: `dbus_byte_en`=1100, `dbus_wdata`=0xABCD_ABCD, `dbus_addr`=0x200. Retire with `wb_wen`=0.
- LW at 0x101: `misaligned` pulses, and there is no `dbus_ren`, no `regWEN` and no `wb_wen`.
- `flush` during MEM_REQ of a load: the bus completes, `wb_wen` stays 0, and the state returns to EMPTY. `flush` in ALU: no `wb_wen`.
- `RST` asserted while `dbus_ren`=1: in the next cycle all outputs are 0 and `ex_ready`=1. `rd`=0 ALU op: `regWEN`=0.
